// File: rtl/bullet_fire_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : bullet_fire_scheduler
// Description : Per-tank shot scheduler: picks a free bullet slot on a fire
//               press, latches the tank pose and triggers the slot until it
//               acknowledges, then enforces a re-fire cooldown.
//               Optional macro BULLET_SCHED_AUTOFIRE_EN: a held fire button
//               re-arms at the end of each cooldown.
// Revision    : 1.0 - initial release
// ============================================================================
module bullet_fire_scheduler #(
  parameter int NUM_SLOTS   = 5,
  parameter int COOLDOWN    = 6,
  parameter int ACK_TIMEOUT = 3
) (
  input  logic                               i_frame_clk,
  input  logic                               i_reset_n,
  input  logic                               i_enable,
  input  logic                               i_fire,
  input  logic [6:0]                         i_tank_angle,
  input  logic [9:0]                         i_tank_x,
  input  logic [9:0]                         i_tank_y,
  input  logic [NUM_SLOTS-1:0]               i_slot_shot,
  output logic [NUM_SLOTS-1:0]               o_trigger,
  output logic [6:0]                         o_shot_angle,
  output logic [9:0]                         o_shot_x,
  output logic [9:0]                         o_shot_y,
  output logic [$clog2(NUM_SLOTS+1)-1:0]     o_active_cnt,
  output logic                               o_fire_reject
);

  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  state_t               r_state;
  logic [NUM_SLOTS-1:0] r_trigger;
  logic [ACK_W-1:0]     r_ack_cnt;
  logic [CD_W-1:0]      r_cd_cnt;
  logic                 r_fire_reject;
  logic                 r_fire_q;
  logic [CNT_W-1:0]     r_active_cnt;
  logic [6:0]           r_shot_angle;
  logic [9:0]           r_shot_x;
  logic [9:0]           r_shot_y;

  state_t               w_state_nxt;
  logic [NUM_SLOTS-1:0] w_trigger_nxt;
  logic [ACK_W-1:0]     w_ack_nxt;
  logic [CD_W-1:0]      w_cd_nxt;
  logic                 w_reject_nxt;
  logic                 w_latch;
  logic                 w_try_fire;
  logic                 w_fire_edge;
  logic                 w_rearm;
  logic                 w_ack;
  logic                 w_free_any;
  logic [NUM_SLOTS-1:0] w_lowest_free;

  assign w_fire_edge   = i_fire & ~r_fire_q;
  // Lowest clear bit of slot_shot; zero when every slot is busy.
  assign w_lowest_free = ~i_slot_shot & (i_slot_shot + NUM_SLOTS'(1));
  assign w_free_any    = ~&i_slot_shot;
  // Trigger stays one-hot on the selected slot while issuing.
  assign w_ack         = |(i_slot_shot & r_trigger);

`ifdef BULLET_SCHED_AUTOFIRE_EN
  assign w_rearm = i_fire;
`else
  assign w_rearm = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_trigger_nxt = r_trigger;
    w_ack_nxt     = r_ack_cnt;
    w_cd_nxt      = r_cd_cnt;
    w_reject_nxt  = 1'b0;
    w_latch       = 1'b0;
    w_try_fire    = 1'b0;

    if (!i_enable) begin
      w_state_nxt   = S_IDLE;
      w_trigger_nxt = '0;
      w_ack_nxt     = '0;
      w_cd_nxt      = '0;
    end else begin
      case (r_state)
        S_IDLE: w_try_fire = w_fire_edge;
        S_ISSUE: begin
          if (w_ack) begin
            w_trigger_nxt = '0;
            w_ack_nxt     = '0;
            w_cd_nxt      = CD_W'(COOLDOWN);
            w_state_nxt   = (COOLDOWN == 0) ? S_IDLE : S_COOLDOWN;
          end else if (r_ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
            // Trigger has now been held ACK_TIMEOUT frames without an ack.
            w_trigger_nxt = '0;
            w_ack_nxt     = '0;
            w_reject_nxt  = 1'b1;
            w_state_nxt   = S_IDLE;
          end else begin
            w_ack_nxt = r_ack_cnt + ACK_W'(1);
          end
        end
        S_COOLDOWN: begin
          if (r_cd_cnt <= CD_W'(1)) begin
            w_cd_nxt    = '0;
            w_state_nxt = S_IDLE;
            w_try_fire  = w_rearm;
          end else begin
            w_cd_nxt = r_cd_cnt - CD_W'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase

      if (w_try_fire) begin
        if (w_free_any) begin
          w_state_nxt   = S_ISSUE;
          w_trigger_nxt = w_lowest_free;
          w_ack_nxt     = '0;
          w_latch       = 1'b1;
        end else begin
          w_reject_nxt  = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge i_frame_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_IDLE;
      r_trigger     <= '0;
      r_ack_cnt     <= '0;
      r_cd_cnt      <= '0;
      r_fire_reject <= 1'b0;
      r_fire_q      <= 1'b1;
      r_active_cnt  <= '0;
      r_shot_angle  <= '0;
      r_shot_x      <= '0;
      r_shot_y      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_trigger     <= w_trigger_nxt;
      r_ack_cnt     <= w_ack_nxt;
      r_cd_cnt      <= w_cd_nxt;
      r_fire_reject <= w_reject_nxt;
      r_fire_q      <= i_fire;
      r_active_cnt  <= CNT_W'($countones(i_slot_shot));
      if (w_latch) begin
        r_shot_angle <= i_tank_angle;
        r_shot_x     <= i_tank_x;
        r_shot_y     <= i_tank_y;
      end
    end
  end

  assign o_trigger     = r_trigger;
  assign o_shot_angle  = r_shot_angle;
  assign o_shot_x      = r_shot_x;
  assign o_shot_y      = r_shot_y;
  assign o_active_cnt  = r_active_cnt;
  assign o_fire_reject = r_fire_reject;

endmodule
`default_nettype wire

// File: tb/tb_bullet_fire_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// Testbench for bullet_fire_scheduler: directed vector table, multi-cycle
// corner sequences and a randomized run against a transaction-level model.
module tb_bullet_fire_scheduler;

  localparam int NS = 5;
  localparam int CD = 6;
  localparam int AT = 3;
`ifdef BULLET_SCHED_AUTOFIRE_EN
  localparam bit AUTOFIRE = 1'b1;
`else
  localparam bit AUTOFIRE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          fire;
  logic [6:0]    ang;
  logic [9:0]    tx, ty;
  logic [NS-1:0] ss;
  logic [NS-1:0] trig;
  logic [6:0]    s_ang;
  logic [9:0]    s_x, s_y;
  logic [2:0]    cnt;
  logic          rej;

  int tests = 0;
  int fails = 0;

  bullet_fire_scheduler #(.NUM_SLOTS(NS), .COOLDOWN(CD), .ACK_TIMEOUT(AT)) dut (
    .i_frame_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_fire(fire),
    .i_tank_angle(ang), .i_tank_x(tx), .i_tank_y(ty), .i_slot_shot(ss),
    .o_trigger(trig), .o_shot_angle(s_ang), .o_shot_x(s_x), .o_shot_y(s_y),
    .o_active_cnt(cnt), .o_fire_reject(rej)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; fire = 1'b0; ss = '0;
    ang = '0; tx = '0; ty = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- transaction-level reference model ----------------
  int            m_busy;
  int            m_age;
  int            m_cool;
  bit            m_prev_fire;
  logic [NS-1:0] m_trig;
  logic          m_rej;
  logic [2:0]    m_cnt;
  logic [6:0]    m_a;
  logic [9:0]    m_x, m_y;

  task automatic model_reset();
    m_busy = -1; m_age = 0; m_cool = 0; m_prev_fire = 1'b1;
    m_trig = '0; m_rej = 1'b0; m_cnt = '0; m_a = '0; m_x = '0; m_y = '0;
  endtask

  // Predicts the outputs after the next rising edge given the inputs presented to it.
  task automatic model_step();
    bit want;
    int pick;
    bit press;
    press = fire && !m_prev_fire;
    want  = 1'b0;
    m_prev_fire = fire;
    m_rej = 1'b0;
    m_cnt = 3'($countones(ss));
    if (!en) begin
      m_busy = -1; m_cool = 0;
    end else if (m_busy >= 0) begin
      if (ss[m_busy]) begin
        m_busy = -1; m_cool = CD;
      end else begin
        m_age++;
        if (m_age == AT) begin m_busy = -1; m_rej = 1'b1; end
      end
    end else if (m_cool > 0) begin
      m_cool--;
      if (m_cool == 0) want = AUTOFIRE && fire;
    end else begin
      want = press;
    end
    if (want) begin
      pick = -1;
      for (int i = NS - 1; i >= 0; i--) if (!ss[i]) pick = i;
      if (pick < 0) m_rej = 1'b1;
      else begin
        m_busy = pick; m_age = 0; m_a = ang; m_x = tx; m_y = ty;
      end
    end
    m_trig = (m_busy >= 0) ? NS'(1 << m_busy) : '0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          en, fire;
    logic [NS-1:0] ss;
    logic [6:0]    a;
    logic [9:0]    x, y;
    logic [NS-1:0] e_trig;
    logic          e_rej;
    logic [2:0]    e_cnt;
    logic [6:0]    e_a;
    logic [9:0]    e_x, e_y;
  } vec_t;
  vec_t tbl[$];

  task automatic add_vec(input logic f, input logic [NS-1:0] s, input logic [6:0] a,
                         input logic [9:0] x, input logic [9:0] y, input logic [NS-1:0] et,
                         input logic er, input logic [2:0] ec, input logic [6:0] ea,
                         input logic [9:0] ex, input logic [9:0] ey);
    vec_t v;
    v.en = 1'b1; v.fire = f; v.ss = s; v.a = a; v.x = x; v.y = y;
    v.e_trig = et; v.e_rej = er; v.e_cnt = ec; v.e_a = ea; v.e_x = ex; v.e_y = ey;
    tbl.push_back(v);
  endtask

  int shots, rejects, first_shot, second_shot;
  logic [NS-1:0] prev_trig, seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Row order matters: each row is one frame, expectations are post-edge.
    add_vec(1'b0, 5'b00101, 7'd37, 10'd120, 10'd200, 5'b00000, 1'b0, 3'd2, 7'd0,  10'd0,   10'd0);
    add_vec(1'b1, 5'b00101, 7'd37, 10'd120, 10'd200, 5'b00010, 1'b0, 3'd2, 7'd37, 10'd120, 10'd200);
    add_vec(1'b1, 5'b00111, 7'd99, 10'd200, 10'd300, 5'b00000, 1'b0, 3'd3, 7'd37, 10'd120, 10'd200);
    add_vec(1'b0, 5'b00111, 7'd99, 10'd200, 10'd300, 5'b00000, 1'b0, 3'd3, 7'd37, 10'd120, 10'd200);
    add_vec(1'b1, 5'b00111, 7'd99, 10'd200, 10'd300, 5'b00000, 1'b0, 3'd3, 7'd37, 10'd120, 10'd200);
    add_vec(1'b0, 5'b00111, 7'd99, 10'd200, 10'd300, 5'b00000, 1'b0, 3'd3, 7'd37, 10'd120, 10'd200);
    add_vec(1'b1, 5'b00111, 7'd99, 10'd200, 10'd300, 5'b00000, 1'b0, 3'd3, 7'd37, 10'd120, 10'd200);
    add_vec(1'b0, 5'b00111, 7'd99, 10'd200, 10'd300, 5'b00000, 1'b0, 3'd3, 7'd37, 10'd120, 10'd200);
    add_vec(1'b0, 5'b00111, 7'd99, 10'd200, 10'd300, 5'b00000, 1'b0, 3'd3, 7'd37, 10'd120, 10'd200);
    add_vec(1'b1, 5'b00111, 7'd5,  10'd6,   10'd7,   5'b01000, 1'b0, 3'd3, 7'd5,  10'd6,   10'd7);
    add_vec(1'b1, 5'b01111, 7'd99, 10'd200, 10'd300, 5'b00000, 1'b0, 3'd4, 7'd5,  10'd6,   10'd7);
    for (int k = 0; k < 6; k++)
      add_vec(1'b0, 5'b11111, 7'd99, 10'd200, 10'd300, 5'b00000, 1'b0, 3'd5, 7'd5, 10'd6, 10'd7);
    add_vec(1'b1, 5'b11111, 7'd99, 10'd200, 10'd300, 5'b00000, 1'b1, 3'd5, 7'd5,  10'd6,   10'd7);
    add_vec(1'b1, 5'b11111, 7'd99, 10'd200, 10'd300, 5'b00000, 1'b0, 3'd5, 7'd5,  10'd6,   10'd7);

    rst_n = 1'b0; en = 1'b0; fire = 1'b0; ss = '0; ang = '0; tx = '0; ty = '0;
    @(negedge clk);
    check("reset_trigger", 32'(trig), 32'd0);
    check("reset_cnt", 32'(cnt), 32'd0);
    check("reset_reject", 32'(rej), 32'd0);
    check("reset_shot", 32'({s_ang, s_x, s_y}), 32'd0);
    do_reset();

    foreach (tbl[i]) begin
      en = tbl[i].en; fire = tbl[i].fire; ss = tbl[i].ss;
      ang = tbl[i].a; tx = tbl[i].x; ty = tbl[i].y;
      step();
      check($sformatf("vec%0d_trigger", i), 32'(trig), 32'(tbl[i].e_trig));
      check($sformatf("vec%0d_reject", i), 32'(rej), 32'(tbl[i].e_rej));
      check($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(tbl[i].e_cnt));
      check($sformatf("vec%0d_shot", i), 32'({s_ang, s_x, s_y}),
            32'({tbl[i].e_a, tbl[i].e_x, tbl[i].e_y}));
    end

    // Ack timeout: trigger held exactly AT frames, then a reject pulse.
    do_reset();
    en = 1'b1; step();
    fire = 1'b1; step();
    for (int k = 0; k < AT; k++) begin
      check($sformatf("timeout_hold%0d", k), 32'(trig), 32'd1);
      check("timeout_no_reject_yet", 32'(rej), 32'd0);
      step();
    end
    check("timeout_drop", 32'(trig), 32'd0);
    check("timeout_reject", 32'(rej), 32'd1);
    step();
    check("timeout_reject_once", 32'(rej), 32'd0);
    fire = 1'b0; step();
    fire = 1'b1; step();
    check("timeout_repress", 32'(trig), 32'd1);
    en = 1'b0; step();
    check("enable_drop_trigger", 32'(trig), 32'd0);
    en = 1'b1; step();
    check("enable_back_no_edge", 32'(trig), 32'd0);

    // Asynchronous reset mid-issue with fire held through release.
    do_reset();
    en = 1'b1; ss = 5'b00011; step();
    fire = 1'b1; step();
    check("t1_trigger2", 32'(trig), 32'b00100);
    ss = 5'b10011; step();
    check("t1_cnt_before", 32'(cnt), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("t1_async_trigger", 32'(trig), 32'd0);
    check("t1_async_cnt", 32'(cnt), 32'd0);
    step(); step();
    rst_n = 1'b1; ss = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t1_held_no_shot", 32'(trig), 32'd0);
    end

    // Fire held for many frames, slots ack one frame after seeing trigger.
    do_reset();
    en = 1'b1; step();
    fire = 1'b1;
    shots = 0; rejects = 0; first_shot = -1; second_shot = -1;
    prev_trig = '0; seen = '0;
    for (int k = 1; k <= 48; k++) begin
      step();
      if (trig != '0 && prev_trig == '0) begin
        shots++;
        if (first_shot < 0) first_shot = k;
        else if (second_shot < 0) second_shot = k;
      end
      if (rej) rejects++;
      prev_trig = trig;
      for (int i = 0; i < NS; i++) begin
        if (trig[i] && seen[i]) ss[i] = 1'b1;
        seen[i] = trig[i];
      end
    end
    fire = 1'b0;
    if (AUTOFIRE) begin
      check("t6_auto_shots", 32'(shots), 32'd5);
      check("t6_auto_rejects", 32'(rejects), 32'd1);
      check("t6_auto_period", 32'(second_shot - first_shot), 32'd8);
    end else begin
      check("t6_single_shot", 32'(shots), 32'd1);
      check("t6_no_reject", 32'(rejects), 32'd0);
    end

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int k = 0; k < 2000; k++) begin
      en = ($urandom_range(0, 99) < 96);
      if ($urandom_range(0, 2) == 0) fire = ~fire;
      ang = 7'($urandom); tx = 10'($urandom); ty = 10'($urandom);
      for (int i = 0; i < NS; i++) begin
        if (ss[i]) begin
          if ($urandom_range(0, 11) == 0) ss[i] = 1'b0;
        end else if (m_trig[i]) begin
          if ($urandom_range(0, 2) != 0) ss[i] = 1'b1;
        end else if ($urandom_range(0, 39) == 0) begin
          ss[i] = 1'b1;
        end
      end
      model_step();
      step();
      check("rnd_trigger", 32'(trig), 32'(m_trig));
      check("rnd_reject", 32'(rej), 32'(m_rej));
      check("rnd_cnt", 32'(cnt), 32'(m_cnt));
      check("rnd_shot", 32'({s_ang, s_x, s_y}), 32'({m_a, m_x, m_y}));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
